// File: rtl/seq_restoring_divider.sv
// ============================================================================
// seq_restoring_divider : one-quotient-bit-per-cycle restoring divider | rev 1.0
// ============================================================================
`default_nettype none

module seq_restoring_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic             accept;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem, quo, dsr;
   logic             neg_q, neg_r, zero_div;

   logic             dvd_neg, dsr_neg;
   logic [WIDTH-1:0] dvd_mag, dsr_mag;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] trial;
   logic             fits;
   logic [WIDTH-1:0] rem_step, quo_step;

   always_comb begin
      dvd_neg  = is_signed & dividend[WIDTH-1];
      dsr_neg  = is_signed & divisor[WIDTH-1];
      dvd_mag  = dvd_neg ? (~dividend + 1'b1) : dividend;
      dsr_mag  = dsr_neg ? (~divisor + 1'b1) : divisor;
      // Partial remainder is below the divisor, so a successful trial always fits WIDTH bits.
      shifted  = {rem, quo[WIDTH-1]};
      fits     = (shifted >= {1'b0, dsr});
      trial    = shifted[WIDTH-1:0] - dsr;
      rem_step = fits ? trial : shifted[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], fits};
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      case (state)
         S_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN:   if (count == '0) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // A zero divisor takes a single RUN cycle (count loaded with 0) before DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         count       <= '0;
         rem         <= '0;
         quo         <= '0;
         dsr         <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         zero_div    <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         zero_div    <= (divisor == '0);
         count       <= (divisor == '0) ? '0 : CW'(WIDTH - 1);
         rem         <= '0;
         quo         <= (divisor == '0) ? dividend : dvd_mag;
         dsr         <= dsr_mag;
         neg_q       <= dvd_neg ^ dsr_neg;
         neg_r       <= dvd_neg;
         div_by_zero <= 1'b0;
      end else if (state == S_RUN) begin
         if (zero_div) begin
            quotient    <= '1;
            remainder   <= quo;
            div_by_zero <= 1'b1;
         end else begin
            rem   <= rem_step;
            quo   <= quo_step;
            count <= count - 1'b1;
            if (count == '0) begin
               quotient  <= neg_q ? (~quo_step + 1'b1) : quo_step;
               remainder <= neg_r ? (~rem_step + 1'b1) : rem_step;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// ============================================================================
// tb_seq_restoring_divider : directed + random checks against an arithmetic model | rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_restoring_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int tests = 0;
   int fails = 0;

   seq_restoring_divider #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .is_signed  (is_signed),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Truncating division on 64-bit integers, RISC-V rule for a zero divisor.
   function automatic void model(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r, output bit z);
      longint sa, sb, lq, lr;
      z = (b == 32'd0);
      if (z) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else begin
         sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
         sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
         lq = sa / sb;
         lr = sa % sb;
         q  = lq[31:0];
         r  = lr[31:0];
      end
   endfunction

   // Entered at a negedge; leaves at the negedge after the done cycle.
   task automatic run_op(input string tag, input bit sg, input logic [31:0] a,
                         input logic [31:0] b, input int poke_at, input bit poke_done);
      logic [31:0] eq, er;
      bit          ez;
      int          lat, busy_cnt, exp_lat;
      model(sg, a, b, eq, er, ez);
      exp_lat   = ez ? 2 : 33;
      is_signed = sg;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      lat      = 1;
      busy_cnt = 0;
      while (1) begin
         if (busy) busy_cnt++;
         if (done || lat >= 100) break;
         if (lat == poke_at) begin
            start     = 1'b1;
            dividend  = $urandom;
            divisor   = $urandom_range(1, 255);
            is_signed = ~sg;
         end
         @(negedge clk);
         start = 1'b0;
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
      check({tag, "_quotient"}, quotient, eq);
      check({tag, "_remainder"}, remainder, er);
      check({tag, "_div_by_zero"}, {31'd0, div_by_zero}, {31'd0, ez});
      if (poke_done) begin
         start    = 1'b1;
         dividend = 32'd77;
         divisor  = 32'd3;
      end
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
      check({tag, "_done_after"}, {31'd0, done}, 32'd0);
      check({tag, "_q_held"}, quotient, eq);
   endtask

   initial begin
      int          done_seen;
      logic [31:0] ra, rb;
      bit          rs;

      rst       = 1'b1;
      start     = 1'b0;
      is_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_quotient", quotient, 32'd0);
      check("reset_remainder", remainder, 32'd0);
      check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op("u100_7", 1'b0, 32'd100, 32'd7, 0, 1'b0);
      check("u100_7_q_const", quotient, 32'd14);
      check("u100_7_r_const", remainder, 32'd2);
      run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
      check("s_m7_2_q_const", quotient, 32'hFFFF_FFFD);
      run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
      check("s_7_m2_r_const", remainder, 32'd1);
      run_op("div0", 1'b0, 32'h1234, 32'd0, 0, 1'b0);
      check("div0_q_const", quotient, 32'hFFFF_FFFF);
      run_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
      check("s_min_m1_q_const", quotient, 32'h8000_0000);
      run_op("u_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
      check("u_min_m1_r_const", remainder, 32'h8000_0000);

      // Mid-run start ignored, start in DONE ignored, back-to-back start accepted.
      run_op("poke_run", 1'b0, 32'd1000, 32'd9, 10, 1'b1);
      run_op("b2b", 1'b1, 32'hFFFF_FC18, 32'd7, 0, 1'b0);

      // Reset mid-run: abort with no done pulse.
      is_signed = 1'b0;
      dividend  = 32'd123456;
      divisor   = 32'd11;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_quotient", quotient, 32'd0);
      check("abort_remainder", remainder, 32'd0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      check("abort_no_done", done_seen, 32'd0);
      run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);

      for (int n = 0; n < 24; n++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = $urandom_range(1, 15);
            2:       rb = 32'hFFFF_FFFF - $urandom_range(0, 15);
            default: rb = $urandom;
         endcase
         run_op("rand", rs, ra, rb, 0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
